// File: rtl/divider_ctrl_if.sv
// Control bundle between the divider sequencer and its datapath/requester.
//
// Handshake: `start` is a request with no ready. The controller samples it
// only while idle (busy=0, done=0) and ignores it in every other cycle; it is
// never queued. `done` is a single-cycle pulse marking the cycle in which the
// datapath results are valid. `busy` is high from LOAD through FINAL. `sign`
// is the datapath remainder sign. It must be a registered datapath output,
// because the controller decodes `add`/`sel` from it in the same cycle.
interface divider_ctrl_if;
  logic       start;
  logic       sign;
  logic       load;
  logic       add;
  logic       shift;
  logic       inbit;
  logic [1:0] sel;
  logic       busy;
  logic       done;

  // Controller side
  modport master (
    input  start, sign,
    output load, add, shift, inbit, sel, busy, done
  );

  // Datapath / requester side
  modport slave (
    output start, sign,
    input  load, add, shift, inbit, sel, busy, done
  );
endinterface

// File: rtl/divider_ctrl.sv
// Sequencer for the 8-by-7 restoring divider datapath. A start request runs
// LOAD, then NITER rounds of SHIFT/SUB/CHK, then FINAL and a one-cycle DONE.
// Outputs are registered. The exceptions are the CHK restore (`add`/`sel`),
// which follows the registered datapath sign, and `inbit`, which is decoded
// from the state and the qbit register.
module divider_ctrl #(
  parameter int NITER = 8
) (
  input  logic           clk,
  input  logic           reset,
  divider_ctrl_if.master bus,
  output logic [2:0]     dbg_state
);

  // One extra count value so the counter can reach NITER without wrapping.
  localparam int CW = $clog2(NITER + 1);
  localparam logic [CW-1:0] LAST = CW'(NITER - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_CHK   = 3'd4,
    S_FINAL = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          qbit;
  logic          load_r;
  logic          add_r;
  logic          shift_r;
  logic [1:0]    sel_r;
  logic          busy_r;
  logic          done_r;
  logic          restore;

  // FSM and registered outputs. Each transition also loads the outputs that
  // belong to the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      qbit    <= 1'b0;
      load_r  <= 1'b0;
      add_r   <= 1'b0;
      shift_r <= 1'b0;
      sel_r   <= 2'b00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      load_r  <= 1'b0;
      add_r   <= 1'b0;
      shift_r <= 1'b0;
      sel_r   <= 2'b00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_LOAD;
            load_r <= 1'b1;
            busy_r <= 1'b1;
          end
        end
        S_LOAD: begin
          // The first shift sees qbit=0; that bit falls off the quotient top.
          state   <= S_SHIFT;
          cnt     <= '0;
          qbit    <= 1'b0;
          shift_r <= 1'b1;
          busy_r  <= 1'b1;
        end
        S_SHIFT: begin
          state  <= S_SUB;
          add_r  <= 1'b1;
          sel_r  <= 2'b01;
          busy_r <= 1'b1;
        end
        S_SUB: begin
          state  <= S_CHK;
          busy_r <= 1'b1;
        end
        S_CHK: begin
          qbit    <= ~bus.sign;
          cnt     <= cnt + CW'(1);
          shift_r <= 1'b1;
          busy_r  <= 1'b1;
          if (cnt < LAST) begin
            state <= S_SHIFT;
          end else begin
            state <= S_FINAL;
            sel_r <= 2'b11;
          end
        end
        S_FINAL: begin
          state  <= S_DONE;
          done_r <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A negative trial remainder in CHK is restored in the same cycle.
  assign restore = (state == S_CHK) && bus.sign;

  assign bus.load  = load_r;
  assign bus.add   = add_r | restore;
  assign bus.shift = shift_r;
  assign bus.sel   = sel_r | (restore ? 2'b10 : 2'b00);
  assign bus.inbit = ((state == S_SHIFT) || (state == S_FINAL)) && qbit;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: a behavioural restoring-divider datapath driven by
// the controller, per-cycle output timing checks, and a result scoreboard.
module tb_divider_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;
  logic [7:0] a_in = '0;
  logic [6:0] b_in = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int proto_viol = 0;

  logic [15:0] exp_q[$];

  divider_ctrl_if bus();

  divider_ctrl #(.NITER(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural datapath: 8-bit quotient/dividend register, 9-bit signed remainder.
  logic [7:0] dp_q = '0;
  logic [6:0] dp_d = '0;
  logic [8:0] dp_r = '0;

  always @(posedge clk) begin
    if (bus.load) begin
      dp_q <= a_in;
      dp_d <= b_in;
      dp_r <= '0;
    end else if (bus.shift) begin
      if (bus.sel == 2'b11) begin
        dp_q <= {dp_q[6:0], bus.inbit};
      end else begin
        dp_r <= {dp_r[7:0], dp_q[7]};
        dp_q <= {dp_q[6:0], bus.inbit};
      end
    end else if (bus.add) begin
      if (bus.sel == 2'b01) dp_r <= dp_r - {2'b00, dp_d};
      else if (bus.sel == 2'b10) dp_r <= dp_r + {2'b00, dp_d};
    end
  end

  assign bus.sign = dp_r[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Protocol monitor and scoreboard pop on done.
  logic [15:0] sb_exp;
  always @(negedge clk) begin
    if (reset) begin
      if ((int'(bus.load) + int'(bus.add) + int'(bus.shift)) > 1) proto_viol++;
      if (bus.sel == 2'b11 && !bus.shift) proto_viol++;
      if (bus.done === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_done: got q=%0d r=%0d expected no result", dp_q, dp_r[7:0]);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({dp_q, dp_r[7:0]} !== sb_exp) begin
            n_fail++;
            $display("FAIL sb_result: got q=%0d r=%0d expected q=%0d r=%0d",
                     dp_q, dp_r[7:0], sb_exp[15:8], sb_exp[7:0]);
          end
        end
      end
    end
  end

  // Reference divider, independent of the sequencing.
  task automatic ref_div(input logic [7:0] a, input logic [6:0] b,
                         output logic [7:0] q, output logic [7:0] r);
    if (b == 0) begin
      q = 8'hff;
      r = a;
    end else begin
      q = a / {1'b0, b};
      r = a % {1'b0, b};
    end
  endtask

  // Drives one division and checks the output sequence cycle by cycle.
  // k counts cycles after the start-sampling cycle (k=1 is LOAD).
  task automatic run_div(input logic [7:0] a, input logic [6:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input bit pulses);
    int done_k = -1;
    int terr = 0;
    int first_bad = -1;
    int rest_n = 0;
    int fin_inbit = -1;
    bit e_load, e_shift, e_sub, e_chk, e_busy, e_done, bad;
    @(negedge clk);
    a_in = a;
    b_in = b;
    bus.start = 1'b1;
    exp_q.push_back({eq, er});
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      e_load  = (k == 1);
      e_shift = (k >= 2 && k <= 26 && (k - 2) % 3 == 0);
      e_sub   = (k >= 3 && k <= 24 && (k - 3) % 3 == 0);
      e_chk   = (k >= 4 && k <= 25 && (k - 4) % 3 == 0);
      e_busy  = (k >= 1 && k <= 26);
      e_done  = (k == 27);
      bad = (bus.load !== e_load) || (bus.shift !== e_shift) ||
            (bus.busy !== e_busy) || (bus.done !== e_done);
      if (e_sub) begin
        bad = bad || (bus.add !== 1'b1) || (bus.sel !== 2'b01);
      end else if (e_chk) begin
        bad = bad || !((bus.add === 1'b1 && bus.sel === 2'b10) ||
                       (bus.add === 1'b0 && bus.sel === 2'b00));
        if (bus.add === 1'b1) rest_n++;
      end else begin
        bad = bad || (bus.add !== 1'b0) || (bus.sel !== ((k == 26) ? 2'b11 : 2'b00));
      end
      if (k == 2) bad = bad || (bus.inbit !== 1'b0);
      if (k == 26) fin_inbit = int'(bus.inbit);
      if (bus.done === 1'b1 && done_k < 0) done_k = k;
      if (bad) begin
        terr++;
        if (first_bad < 0) first_bad = k;
      end
      if (pulses) bus.start = (k == 5 || k == 27);
    end
    bus.start = 1'b0;
    check($sformatf("done_cycle %0d/%0d", a, b), done_k, 27);
    check($sformatf("timing_errs %0d/%0d", a, b), terr, 0);
    if (terr != 0) $display("  first bad cycle %0d", first_bad);
    check($sformatf("restores %0d/%0d", a, b), rest_n, 8 - $countones(eq));
    check($sformatf("final_inbit %0d/%0d", a, b), fin_inbit, int'(eq[0]));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [6:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] ra, rq, rr;
    logic [6:0] rb;
    int ndone, nload, bad_done;

    vecs[0] = '{8'd100, 7'd7,   8'd14,  8'd2};
    vecs[1] = '{8'd5,   7'd9,   8'd0,   8'd5};
    vecs[2] = '{8'd255, 7'd1,   8'd255, 8'd0};
    vecs[3] = '{8'd200, 7'd13,  8'd15,  8'd5};
    vecs[4] = '{8'd77,  7'd0,   8'd255, 8'd77};
    vecs[5] = '{8'd127, 7'd127, 8'd1,   8'd0};
    vecs[6] = '{8'd0,   7'd5,   8'd0,   8'd0};
    vecs[7] = '{8'd254, 7'd127, 8'd2,   8'd0};

    // Reset
    bus.start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({bus.load, bus.add, bus.shift, bus.inbit, bus.sel, bus.busy, bus.done}), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", int'({bus.load, bus.add, bus.shift, bus.sel, bus.busy, bus.done}), 0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0);
    end

    // Reset priority over start in IDLE; start is not remembered afterwards.
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    check("reset_vs_start_load", int'({bus.load, bus.busy}), 0);
    reset = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("no_queued_start", int'({bus.load, bus.busy}), 0);

    // Reset mid-operation (cycle 12 is a SUB)
    @(negedge clk);
    a_in = 8'd100;
    b_in = 7'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 12) begin
        check("midop_in_sub", int'({bus.add, bus.sel}), 3'b101);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    check("midop_reset_outputs", int'({bus.load, bus.add, bus.shift, bus.inbit, bus.sel, bus.busy, bus.done}), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midop_stays_idle", int'({bus.busy, bus.done}), 0);
    run_div(8'd200, 7'd13, 8'd15, 8'd5, 1'b0);

    // Pulses of start during busy and in the DONE cycle are ignored.
    run_div(8'd100, 7'd7, 8'd14, 8'd2, 1'b1);
    check("ignored_pulses_sb_empty", exp_q.size(), 0);

    // start held high: back-to-back operations, 28-cycle period.
    repeat (2) @(negedge clk);
    a_in = 8'd100;
    b_in = 7'd7;
    repeat (3) exp_q.push_back({8'd14, 8'd2});
    ndone = 0;
    nload = 0;
    bad_done = 0;
    bus.start = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (!(k == 27 || k == 55 || k == 83)) bad_done++;
      end
      if (bus.load === 1'b1) nload++;
      if (k == 83) bus.start = 1'b0;
    end
    check("hold_done_count", ndone, 3);
    check("hold_load_count", nload, 3);
    check("hold_done_spacing", bad_done, 0);
    check("hold_sb_empty", exp_q.size(), 0);

    // Random operands against the reference divider
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 7'($urandom_range(0, 127));
      ref_div(ra, rb, rq, rr);
      run_div(ra, rb, rq, rr, 1'b0);
    end

    check("protocol_violations", proto_viol, 0);
    check("sb_final_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/divider_ctrl.md
# divider_ctrl

Sequencing controller for the 8-bit-by-7-bit restoring divider datapath. On a start pulse it loads the operands, then runs a fixed eight-iteration shift / trial-subtract / conditional-restore sequence, driving the datapath's `load`, `add`, `shift`, `inbit` and `sel` controls and reading back its `sign` flag. Latency is fixed, so the result-valid point is predictable. It sits beside `datapath` inside the divider top level and is the only driver of the datapath control inputs.

## Interface
- `NITER`, default 8: number of quotient bits (iterations); the counter width is sized to fit it.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` input 1: request a division; sampled only in IDLE.
- `sign` input 1: datapath sign flag, valid in the cycle after a SUB.
- `load` output 1: datapath loads dividend/divisor, clears remainder.
- `add` output 1: datapath ALU result written to the remainder.
- `shift` output 1: datapath shift-left; behaviour selected by `sel`.
- `inbit` output 1: bit shifted into quotient[0] when `shift`=1.
- `sel` output 2: datapath op select.
  - 00 hold/none.
  - 01 remainder minus divisor.
  - 10 remainder plus divisor (restore).
  - 11 quotient-only shift.
- `busy` output 1: high from LOAD through FINAL.
- `done` output 1: one-cycle pulse; datapath results valid.

## Operation
- States:
  - IDLE: all outputs 0.
  - LOAD: `load`=1.
  - SHIFT: `shift`=1, `sel`=00, `inbit`=qbit.
  - SUB: `add`=1, `sel`=01.
  - CHK:
    - If `sign`=1: `add`=1, `sel`=10, qbit<=0.
    - If `sign`=0: all controls 0, qbit<=1.
  - FINAL: `shift`=1, `sel`=11, `inbit`=qbit.
  - DONE: `done`=1.
- Transitions:
  - IDLE -> LOAD when `start`=1.
  - LOAD -> SHIFT.
  - SHIFT -> SUB.
  - SUB -> CHK.
  - CHK -> SHIFT while the iteration count is below `NITER`-1; otherwise CHK -> FINAL.
  - FINAL -> DONE.
  - DONE -> IDLE unconditionally.
- Iteration counter:
  - Cleared in LOAD.
  - Incremented on leaving CHK.
  - Never wraps within an operation.
- qbit register:
  - Cleared in LOAD, so the first SHIFT shifts in 0.
  - Each later SHIFT, and FINAL, shifts in the previous iteration's quotient bit.
  - The quotient register therefore shifts `NITER`+1 times. The first `inbit` falls off the top, leaving exactly `NITER` quotient bits.
- All outputs are decoded from the state register plus qbit. The only combinational dependency on an input is `add`/`sel` in CHK, which depend on `sign`. `sign` must come from a datapath register.
- `start` is ignored in every state except IDLE. It is not queued, and the DONE cycle does not accept it.
- No divide-by-zero detection: divisor 0 runs the normal sequence, with all CHK cycles seeing `sign`=0.
- Reset (`reset`=0 at an edge): next state IDLE, counter 0, qbit 0, every output 0 in the following cycle. This holds in any state, including mid-iteration. Reset has priority over `start`.

## Timing
- Cycle 0 = the IDLE cycle in which `start`=1 is sampled.
- Cycle 1: LOAD.
- Iteration i (0..`NITER`-1):
  - SHIFT at cycle 2+3i.
  - SUB at cycle 3+3i.
  - CHK at cycle 4+3i.
- FINAL at cycle 3·`NITER`+2, which is 26 for `NITER`=8.
- DONE at cycle 3·`NITER`+3 (27). `done` is high for exactly one cycle.
- `busy` is high in cycles 1..26 and low in IDLE and DONE.
- Results on the datapath outputs are stable from the DONE cycle until the next LOAD.
- Earliest next `start`: sampled in the cycle after DONE, giving a 28-cycle minimum start-to-start period.
- Exactly one of `load`/`add`/`shift` is high per cycle, or none is.

## Test plan
- 100 / 7 with start pulse at cycle 0:
  - `done` pulses at cycle 27 only.
  - quotient=14, remainder=2.
  - `busy` high cycles 1-26.
- 5 / 9: every CHK sees `sign`=1 and issues a restore (`add`=1, `sel`=10); quotient=0, remainder=5.
- 255 / 1: no restores; every CHK has all controls 0; FINAL `inbit`=1; quotient=255, remainder=0.
- Reset low at cycle 12 (mid-SUB):
  - Next cycle IDLE with all outputs 0.
  - A new start of 200 / 13 then gives quotient=15, remainder=5, with `done` 27 cycles after that start.
- `start` held high continuously:
  - Operations run back-to-back with a 28-cycle period.
  - Pulses of `start` during `busy` or DONE are ignored; `done` count equals accepted starts.
- Protocol check over random operands against a reference divider:
  - Never more than one of `load`/`add`/`shift` high.
  - `sel`=11 only in FINAL.
  - Quotient/remainder match.
